// File: rtl/rr_stream_mux_if.sv
// Stream bundle between producers, the round-robin mux and its consumer.
// With RR_STREAM_MUX_PACKET_LOCK_EN defined, per-channel in_last and out_last are carried as well.
interface rr_stream_mux_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);

  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;
`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
  logic [N-1:0]   in_last;
  logic           out_last;
`endif

  modport slave (
    input  in_valid, in_data, out_ready,
`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
    input  in_last,
    output out_last,
`endif
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, out_ready,
`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
    output in_last,
    input  out_last,
`endif
    input  in_ready, out_valid, out_data, out_sel
  );
endinterface

// File: rtl/rr_stream_mux.sv
// N-channel round-robin stream mux with a registered output stage.
// Optional packet lock (winner keeps the grant until in_last) under RR_STREAM_MUX_PACKET_LOCK_EN.
module rr_stream_mux #(
  parameter int N = 4,
  parameter int W = 8
) (
  input logic             clk,
  input logic             rst,
  rr_stream_mux_if.slave  bus
);
  localparam int SW = $clog2(N);
  localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

  logic [SW-1:0] ptr_q, ptr_d;
  logic          outValid_q, outValid_d;
  logic [W-1:0]  outData_q, outData_d;
  logic [SW-1:0] outSel_q, outSel_d;

  logic          load;
  logic          anyValid;
  logic [SW-1:0] grantIdx;
  logic [SW-1:0] nextPtr;
  logic [W-1:0]  grantData;
  logic [N-1:0]  reqMask;
  logic [SW:0]   searchIdx;

`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
  logic          lock_q, lock_d;
  logic [SW-1:0] lockCh_q, lockCh_d;
  logic          outLast_q, outLast_d;

  // While a packet is open only its channel may request, even if it is idle.
  assign reqMask = lock_q ? (bus.in_valid & (N'(1) << lockCh_q)) : bus.in_valid;
  assign bus.out_last = outLast_q;
`else
  assign reqMask = bus.in_valid;
`endif

  assign load = !outValid_q || bus.out_ready;

  // Search wraps at N rather than 2^SW, so indices >= N can never be granted.
  always_comb begin
    anyValid  = 1'b0;
    grantIdx  = '0;
    searchIdx = '0;
    for (int k = 0; k < N; k++) begin
      searchIdx = {1'b0, ptr_q} + (SW+1)'(k);
      if (searchIdx >= (SW+1)'(N)) searchIdx = searchIdx - (SW+1)'(N);
      if (!anyValid && reqMask[searchIdx[SW-1:0]]) begin
        anyValid = 1'b1;
        grantIdx = searchIdx[SW-1:0];
      end
    end
  end

  always_comb begin
    grantData = '0;
    for (int k = 0; k < N; k++) begin
      if (SW'(k) == grantIdx) grantData = bus.in_data[k*W +: W];
    end
  end

  assign nextPtr      = (grantIdx == LAST_IDX) ? '0 : grantIdx + SW'(1);
  assign bus.in_ready = (load && anyValid) ? (N'(1) << grantIdx) : '0;

  always_comb begin
    ptr_d      = ptr_q;
    outValid_d = outValid_q;
    outData_d  = outData_q;
    outSel_d   = outSel_q;
`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
    lock_d     = lock_q;
    lockCh_d   = lockCh_q;
    outLast_d  = outLast_q;
`endif
    if (load && anyValid) begin
      outValid_d = 1'b1;
      outData_d  = grantData;
      outSel_d   = grantIdx;
`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
      outLast_d  = bus.in_last[grantIdx];
      // Priority only rotates once the packet's last beat is taken.
      if (bus.in_last[grantIdx]) begin
        lock_d = 1'b0;
        ptr_d  = nextPtr;
      end else begin
        lock_d   = 1'b1;
        lockCh_d = grantIdx;
      end
`else
      ptr_d      = nextPtr;
`endif
    end else if (bus.out_ready && outValid_q) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      outValid_q <= 1'b0;
      outData_q  <= '0;
      outSel_q   <= '0;
`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
      lock_q     <= 1'b0;
      lockCh_q   <= '0;
      outLast_q  <= 1'b0;
`endif
    end else begin
      ptr_q      <= ptr_d;
      outValid_q <= outValid_d;
      outData_q  <= outData_d;
      outSel_q   <= outSel_d;
`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
      lock_q     <= lock_d;
      lockCh_q   <= lockCh_d;
      outLast_q  <= outLast_d;
`endif
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_data  = outData_q;
  assign bus.out_sel   = outSel_q;
endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux: directed stimulus pushes expected beats,
// a negedge monitor pops and compares every accepted output beat.
module tb_rr_stream_mux;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  typedef struct packed {
    logic [W-1:0]  data;
    logic [SW-1:0] sel;
  } beat_t;

  localparam logic [N-1:0] WRAP_READY [3] = '{4'b1000, 4'b0010, 4'b1000};

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  beat_t expQ[$];
  beat_t expBeat;
  int    testsRun = 0;
  int    testsFailed = 0;

  rr_stream_mux_if #(.N(N), .W(W)) bus ();

  rr_stream_mux #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] valid, input logic [N*W-1:0] data, input logic ready);
    bus.in_valid  = valid;
    bus.in_data   = data;
    bus.out_ready = ready;
  endtask

  task automatic expectBeat(input logic [W-1:0] d, input logic [SW-1:0] s);
    expQ.push_back({d, s});
  endtask

  // Monitor: a beat leaves the register on the edge following a negedge with valid && ready.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (expQ.size() == 0) begin
        testsRun++;
        testsFailed++;
        $display("[TB] FAIL unexpected beat: got data %0h sel %0d, expected none", bus.out_data, bus.out_sel);
      end else begin
        expBeat = expQ.pop_front();
        checkOutput("beat data", 32'(bus.out_data), 32'(expBeat.data));
        checkOutput("beat sel", 32'(bus.out_sel), 32'(expBeat.sel));
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

`ifdef RR_STREAM_MUX_PACKET_LOCK_EN
  initial bus.in_last = '1;
`endif

  initial begin
    applyStimulus('0, '0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset out_data", 32'(bus.out_data), 32'd0);
    checkOutput("reset out_sel", 32'(bus.out_sel), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round robin with all channels busy, ptr starts at 0.
    expectBeat(8'h10, 2'd0);
    expectBeat(8'h11, 2'd1);
    expectBeat(8'h12, 2'd2);
    expectBeat(8'h13, 2'd3);
    expectBeat(8'h10, 2'd0);
    applyStimulus(4'hF, 32'h13121110, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rr no bubble", 32'(bus.out_valid), 32'd1);
    end
    applyStimulus('0, 32'h13121110, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("rr drained", 32'(bus.out_valid), 32'd0);

    // Idle drain: single beat on channel 2 (ptr is 1, moves to 3).
    expectBeat(8'h5A, 2'd2);
    applyStimulus(4'b0100, 32'h005A0000, 1'b1);
    #1;
    checkOutput("idle in_ready", 32'(bus.in_ready), 32'b0100);
    @(posedge clk);
    #1;
    checkOutput("idle one cycle valid", 32'(bus.out_valid), 32'd1);
    applyStimulus('0, '0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("idle drained", 32'(bus.out_valid), 32'd0);

    // Skip and wrap from ptr=3 with channels 1 and 3 valid.
    expectBeat(8'h23, 2'd3);
    expectBeat(8'h21, 2'd1);
    expectBeat(8'h23, 2'd3);
    applyStimulus(4'b1010, 32'h23002100, 1'b1);
    #1;
    for (int i = 0; i < 3; i++) begin
      checkOutput("wrap in_ready", 32'(bus.in_ready), 32'(WRAP_READY[i]));
      @(posedge clk);
      #1;
    end
    applyStimulus('0, '0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("wrap drained", 32'(bus.out_valid), 32'd0);

    // Back-pressure: AB held for 5 cycles, then drain and refill in one edge (ptr 0 -> 1 -> 2).
    expectBeat(8'hAB, 2'd0);
    expectBeat(8'h31, 2'd1);
    applyStimulus(4'b0001, 32'h000000AB, 1'b0);
    @(posedge clk);
    #1;
    applyStimulus(4'hF, 32'h33323130, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checkOutput("bp hold data", 32'(bus.out_data), 32'hAB);
      checkOutput("bp hold valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp in_ready", 32'(bus.in_ready), 32'd0);
      @(posedge clk);
    end
    #1;
    applyStimulus(4'hF, 32'h33323130, 1'b1);
    #1;
    checkOutput("bp refill ready", 32'(bus.in_ready), 32'b0010);
    @(posedge clk);
    #1;
    checkOutput("bp refill data", 32'(bus.out_data), 32'h31);
    checkOutput("bp no bubble", 32'(bus.out_valid), 32'd1);
    applyStimulus('0, '0, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("bp drained", 32'(bus.out_valid), 32'd0);

    // Reset mid-stream: channel 2 is loaded and stalled, then reset asynchronously.
    expectBeat(8'h40, 2'd0);
    applyStimulus(4'hF, 32'h43424140, 1'b0);
    @(posedge clk);
    #3;
    checkOutput("pre-reset data", 32'(bus.out_data), 32'h42);
    rst = 1'b1;
    #1;
    checkOutput("async reset valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async reset data", 32'(bus.out_data), 32'd0);
    checkOutput("async reset sel", 32'(bus.out_sel), 32'd0);
    applyStimulus('0, '0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(4'hF, 32'h43424140, 1'b1);
    #1;
    checkOutput("post-reset grant", 32'(bus.in_ready), 32'b0001);
    @(posedge clk);
    #1;
    applyStimulus('0, '0, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule

// File: doc/rr_stream_mux.md
Name: rr_stream_mux

Overview:
- Parametrised N-channel, W-bit streaming multiplexer with round-robin arbitration and a registered output stage.
- Generalises the 2:1 combinational mux: channel count, data width and selection are no longer fixed, selection is made by a fair arbiter, and every transfer uses a valid/ready handshake.
- Sits between several producer streams and a single consumer, for example merging request queues into one pipeline.

Parameters:
- N, 4, number of input channels (N >= 2).
- W, 8, data width per channel in bits (W >= 1).
- SW, $clog2(N), width of the channel index (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  N  bit i: channel i offers a beat.
- in_data  input  N*W  channel i data is in_data[i*W +: W].
- in_ready  output  N  bit i: channel i beat is accepted this cycle.
- out_valid  output  1  output register holds a beat.
- out_data  output  W  registered beat data.
- out_sel  output  SW  index of the channel that produced out_data.
- out_ready  input  1  consumer accepts the beat this cycle.

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0 (channel 0 highest priority). All state registers clear immediately, including mid-transfer; in-flight beats are discarded.
- Load condition: load = !out_valid || out_ready. The output register may take a new beat when it is empty or being drained in the same cycle, giving full throughput.
- Arbitration (combinational):
  - Search in_valid starting at index ptr and wrapping modulo N.
  - The first asserted bit wins and sets grant index g.
  - No valid input means no grant.
- in_ready[g] = load && any_valid. All other in_ready bits are 0. in_ready depends combinationally on out_ready and in_valid; this path is accepted and is documented here.
- On the clock edge, when load && any_valid:
  - out_data <= in_data[g].
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= (g+1) mod N. The winner drops to lowest priority.
- On the clock edge, when out_ready && out_valid && no grant:
  - out_valid <= 0.
  - out_data and out_sel hold their values (they are don't-care).
- When out_valid && !out_ready: the output register, ptr and all in_ready bits hold (in_ready=0). A producer must keep in_valid/in_data stable until it sees in_ready.
- Latency: one cycle from handshake at the input to out_valid.
- Wrap: when g=N-1, ptr becomes 0.
- Fairness: with all N channels continuously valid and out_ready=1, the grant sequence is strictly cyclic and each channel wins once every N cycles.
- Simultaneous drain and refill in one cycle produces no bubble.
- N not a power of two: ptr wraps at N, not at 2^SW. Indices >= N are never produced.

Optional Feature:
- Macro: RR_STREAM_MUX_PACKET_LOCK_EN.
- Defined:
  - Adds input port in_last (N bits; bit i marks the last beat of a packet on channel i).
  - Adds output out_last (1 bit, registered alongside out_data).
  - Once channel g wins a beat with in_last[g]=0, the arbiter locks to g. Other channels get in_ready=0 even when g is idle.
  - The lock releases after the beat with in_last[g]=1 is accepted; ptr advances only then.
  - Reset clears the lock.
- Undefined: no in_last/out_last ports; every beat is arbitrated independently, as described in Behaviour.

Test Plan:
- Reset mid-stream: assert rst asynchronously while out_valid=1 -> out_valid, out_data, out_sel and ptr read 0 before the next edge; after release, first grant search starts at channel 0.
- Round robin, all busy: N=4, all in_valid=1, in_data[i]=8'h10+i, out_ready=1 -> out_data sequence 10,11,12,13,10 and out_sel 0,1,2,3,0 with no bubbles.
- Skip and wrap: ptr=3, only channels 1 and 3 valid -> grant 3, then 1, then 3; ptr wraps 3->0 after granting channel 3.
- Back-pressure: out_valid=1 holding 8'hAB, out_ready=0 for 5 cycles with new inputs offered -> out_data stays AB, in_ready=0; first cycle out_ready=1 -> drain and refill in the same edge.
- Idle drain: single beat 8'h5A on channel 2 then in_valid=0 -> out_valid for exactly one cycle with out_ready=1, then 0; out_sel=2.
- Packet lock (macro defined): channel 1 sends 3 beats with in_last=0,0,1 while channel 0 is valid throughout -> channel 0 in_ready=0 until channel 1's last beat is accepted, then channel 0 granted.
